// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified single-port instruction/data memory.
// Data-first priority with a fetch starvation guard; 1-cycle responses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch request (held until if_gnt)
//   if_gnt            fetch accepted this cycle (combinational)
//   if_rvalid/rdata/err  fetch response, one cycle after grant
//   d_req/we/addr/wdata  load/store request (held until d_gnt)
//   d_gnt             data accepted this cycle (combinational)
//   d_rvalid/rdata/err   data response (load data or store ack)
//   MWE/MRA/MWD       memory port drive (write on posedge)
//   MRD               memory read data, combinational from MRA
module mem_port_arbiter #(
    parameter int MEM_DEPTH = 551,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        MWE,
    output logic [31:0] MRA,
    output logic [31:0] MWD,
    input  logic [31:0] MRD
);

    localparam logic [31:0] DEPTH    = 32'(MEM_DEPTH);
    localparam logic [3:0]  WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]  starve_cnt;
    logic        fetch_wins;
    logic        if_in;
    logic        d_in;

    logic        if_rvalid_q;
    logic [31:0] if_rdata_q;
    logic        if_err_q;
    logic        d_rvalid_q;
    logic [31:0] d_rdata_q;
    logic        d_err_q;

    assign if_in = (if_addr < DEPTH);
    assign d_in  = (d_addr < DEPTH);

    // Fetch only beats a pending data request once it has been
    // denied MAX_WAIT consecutive cycles.
    assign fetch_wins = ~rst & if_req
                      & (~d_req | (starve_cnt == WAIT_MAX));
    assign if_gnt = fetch_wins;
    assign d_gnt  = ~rst & d_req & ~fetch_wins;

    // Out-of-range accesses park the port at address 0 with
    // writes disabled, so a bad store never touches memory.
    always_comb begin
        MWE = 1'b0;
        MRA = 32'd0;
        MWD = 32'd0;
        unique case (1'b1)
            (if_gnt & if_in): begin
                MRA = if_addr;
            end
            (d_gnt & d_in): begin
                MRA = d_addr;
                MWD = d_wdata;
                MWE = d_we;
            end
            default: begin
                MWE = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt | ~if_req) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != WAIT_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'd0;
            if_err_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
        end else begin
            if_rvalid_q <= if_gnt;
            d_rvalid_q  <= d_gnt;
            if (if_gnt) begin
                if_rdata_q <= if_in ? MRD : 32'd0;
                if_err_q   <= ~if_in;
            end
            if (d_gnt) begin
                d_rdata_q <= (d_in & ~d_we) ? MRD : 32'd0;
                d_err_q   <= ~d_in;
            end
        end
    end

    // A reset in the cycle after a grant squashes the pending
    // response instead of letting it leak out for that cycle.
    assign if_rvalid = if_rvalid_q & ~rst;
    assign d_rvalid  = d_rvalid_q & ~rst;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        MWE;
    logic [31:0] MRA;
    logic [31:0] MWD;
    logic [31:0] MRD;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:550];

    always #5 clk = ~clk;

    assign MRD = (MRA < 32'd551) ? mem[MRA] : 32'd0;

    always @(posedge clk) begin
        if (MWE && MRA < 32'd551) mem[MRA] <= MWD;
    end

    mem_port_arbiter #(.MEM_DEPTH(551), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .MWE(MWE), .MRA(MRA), .MWD(MWD), .MRD(MRD)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_we;
        logic [31:0] e_ra;
        logic [31:0] e_wd;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_ier;
        logic        e_drv;
        logic [31:0] e_drd;
        logic        e_der;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir,
                         input logic [31:0] ia, input logic dr,
                         input logic we, input logic [31:0] da,
                         input logic [31:0] wd);
        rst     = r;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = we;
        d_addr  = da;
        d_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 551; i++) mem[i] = 32'(i * 3);
        mem[2]   = 32'hFFFF_FFFB;
        mem[500] = 32'h2010_0000;
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);

        //          rst ir ia            dr we da   wd
        //          ig dg we ra   wd     irv ird  ier drv drd  der
        vecs[0]  = '{1, 1, 5,            1, 1, 7,   9,
                     0, 0, 0, 0,   0,    0, 0,            0, 0, 0,    0};
        vecs[1]  = '{0, 1, 500,          0, 0, 0,   0,
                     1, 0, 0, 500, 0,    1, 32'h20100000, 0, 0, 0,    0};
        vecs[2]  = '{0, 0, 0,            1, 0, 10,  0,
                     0, 1, 0, 10,  0,    0, 32'h20100000, 0, 1, 30,   0};
        vecs[3]  = '{0, 0, 0,            1, 1, 20,  32'hABCD,
                     0, 1, 1, 20,  32'hABCD,
                                         0, 32'h20100000, 0, 1, 0,    0};
        vecs[4]  = '{0, 1, 20,           0, 0, 0,   0,
                     1, 0, 0, 20,  0,    1, 32'hABCD,     0, 0, 0,    0};
        vecs[5]  = '{0, 1, 551,          0, 0, 0,   0,
                     1, 0, 0, 0,   0,    1, 0,            1, 0, 0,    0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0,   0,
                     0, 0, 0, 0,   0,    0, 0,            1, 0, 0,    0};
        vecs[7]  = '{0, 0, 0,            1, 0, 550, 0,
                     0, 1, 0, 550, 0,    0, 0,            1, 1, 1650, 0};
        vecs[8]  = '{0, 1, 32'h80000002, 0, 0, 0,   0,
                     1, 0, 0, 0,   0,    1, 0,            1, 0, 1650, 0};
        vecs[9]  = '{0, 1, 4,            1, 0, 1,   0,
                     0, 1, 0, 1,   0,    0, 0,            1, 1, 3,    0};
        vecs[10] = '{0, 0, 0,            1, 1, 600, 99,
                     0, 1, 0, 0,   0,    0, 0,            1, 1, 0,    1};

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            drive(vecs[v].rst, vecs[v].if_req, vecs[v].if_addr,
                  vecs[v].d_req, vecs[v].d_we, vecs[v].d_addr,
                  vecs[v].d_wdata);
            #1;
            chk($sformatf("v%0d gnt", v), {30'd0, if_gnt, d_gnt},
                {30'd0, vecs[v].e_ig, vecs[v].e_dg});
            chk($sformatf("v%0d MWE", v), 32'(MWE), 32'(vecs[v].e_we));
            chk($sformatf("v%0d MRA", v), MRA, vecs[v].e_ra);
            chk($sformatf("v%0d MWD", v), MWD, vecs[v].e_wd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rvalid", v), {30'd0, if_rvalid, d_rvalid},
                {30'd0, vecs[v].e_irv, vecs[v].e_drv});
            chk($sformatf("v%0d if_rdata", v), if_rdata, vecs[v].e_ird);
            chk($sformatf("v%0d if_err", v), 32'(if_err), 32'(vecs[v].e_ier));
            chk($sformatf("v%0d d_rdata", v), d_rdata, vecs[v].e_drd);
            chk($sformatf("v%0d d_err", v), 32'(d_err), 32'(vecs[v].e_der));
        end

        // Both requesters held: four data grants, then one fetch.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 4, 1'b1, 1'b0, 5, 0);
            #1;
            chk($sformatf("starve k%0d", k), {30'd0, if_gnt, d_gnt},
                (k % 5 == 4) ? 32'd2 : 32'd1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);

        // Store to 31 wins, then fetch of 31 sees the new word.
        @(negedge clk);
        drive(1'b0, 1'b1, 31, 1'b1, 1'b1, 31, 17);
        #1;
        chk("st gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
        chk("st MWE", 32'(MWE), 32'd1);
        chk("st MRA", MRA, 32'd31);
        chk("st MWD", MWD, 32'd17);
        @(negedge clk);
        drive(1'b0, 1'b1, 31, 1'b0, 1'b0, 0, 0);
        #1;
        chk("st ack", {31'd0, d_rvalid}, 32'd1);
        chk("fe gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
        chk("fe MRA", MRA, 32'd31);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("fe rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fe rdata", if_rdata, 32'd17);

        // Load granted, then reset next cycle squashes its response.
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 0);
        #1;
        chk("rl gnt", {31'd0, d_gnt}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 3, 1'b1, 1'b1, 3, 5);
        #1;
        chk("rl rst gnt", {29'd0, if_gnt, d_gnt, MWE}, 32'd0);
        chk("rl rst MRA", MRA, 32'd0);
        chk("rl rvalid in rst", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rl rvalid after", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        chk("rl rdata clr", d_rdata, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 0);
        @(posedge clk);
        #1;
        chk("rl2 rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("rl2 rdata", d_rdata, 32'hFFFF_FFFB);
        chk("rl2 err", {31'd0, d_err}, 32'd0);
        chk("mem3 intact", mem[3], 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
